// File: rtl/wp_lookup_ctrl.sv
// wp_lookup_ctrl: way-predicted tag lookup controller.
// Probes the predicted way first, then the remaining ways in ascending order,
// one single-way tag read per probe. A hit outside the predicted way trains
// the predictor. Optional statistics counters are enabled by defining
// WP_LOOKUP_STATS_EN.
//
// state | meaning
// IDLE  | waiting for a request (req_ready=1)
// PROBE | tag_rd_en for the current candidate way
// CHECK | compare returned tag/valid, choose next way or finish
// RESP  | hold response until resp_ready
module wp_lookup_ctrl #(
  parameter int NUM_SETS   = 64,
  parameter int NUM_WAYS   = 4,
  parameter int TAG_BITS   = 20,
  parameter int INDEX_BITS = $clog2(NUM_SETS),
  parameter int WAY_BITS   = (NUM_WAYS > 1) ? $clog2(NUM_WAYS) : 1
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  req_valid,
  output logic                  req_ready,
  input  logic [INDEX_BITS-1:0] req_index,
  input  logic [TAG_BITS-1:0]   req_tag,
  output logic [INDEX_BITS-1:0] wp_index,
  input  logic [WAY_BITS-1:0]   wp_pred_way,
  output logic                  wp_update_en,
  output logic [WAY_BITS-1:0]   wp_actual_way,
  output logic                  tag_rd_en,
  output logic [INDEX_BITS-1:0] tag_rd_index,
  output logic [WAY_BITS-1:0]   tag_rd_way,
  input  logic [TAG_BITS-1:0]   tag_rd_tag,
  input  logic                  tag_rd_vld,
  output logic                  resp_valid,
  input  logic                  resp_ready,
  output logic                  resp_hit,
  output logic [WAY_BITS-1:0]   resp_way,
  output logic                  resp_first
`ifdef WP_LOOKUP_STATS_EN
  ,
  output logic [31:0]           stat_first_hit,
  output logic [31:0]           stat_late_hit,
  output logic [31:0]           stat_miss
`endif
);

  typedef enum logic [1:0] {IDLE, PROBE, CHECK, RESP} state_t;

  state_t                state;
  logic [INDEX_BITS-1:0] idx_q;
  logic [TAG_BITS-1:0]   tag_q;
  logic [WAY_BITS-1:0]   cand_q;
  logic [NUM_WAYS-1:0]   tried_q;
  logic                  first_probe_q;
  logic                  cand_first_q;

  logic [WAY_BITS-1:0]   pred_sel;
  logic [WAY_BITS-1:0]   probe_way;
  logic [WAY_BITS-1:0]   next_way;
  logic                  next_found;
  logic                  hit;

  // With a single way the predictor is irrelevant; always probe way 0.
  assign pred_sel     = (NUM_WAYS == 1) ? '0 : wp_pred_way;
  // The predictor is sampled live on the first probe, then the stored candidate is used.
  assign probe_way    = first_probe_q ? pred_sel : cand_q;
  assign req_ready    = (state == IDLE);
  assign wp_index     = (state == IDLE) ? req_index : idx_q;
  assign tag_rd_en    = (state == PROBE);
  assign tag_rd_index = idx_q;
  assign tag_rd_way   = probe_way;
  assign hit          = tag_rd_vld && (tag_rd_tag == tag_q);

  // Lowest-numbered way not yet probed.
  always_comb begin
    next_way   = '0;
    next_found = 1'b0;
    for (int w = NUM_WAYS - 1; w >= 0; w--) begin
      if (!tried_q[w]) begin
        next_found = 1'b1;
        next_way   = WAY_BITS'(w);
      end
    end
  end

  // Lookup sequencer with registered response and predictor-update outputs.
  always_ff @(posedge clk) begin
    if (rst) begin
      state         <= IDLE;
      idx_q         <= '0;
      tag_q         <= '0;
      cand_q        <= '0;
      tried_q       <= '0;
      first_probe_q <= 1'b0;
      cand_first_q  <= 1'b0;
      resp_valid    <= 1'b0;
      resp_hit      <= 1'b0;
      resp_way      <= '0;
      resp_first    <= 1'b0;
      wp_update_en  <= 1'b0;
      wp_actual_way <= '0;
    end else begin
      wp_update_en <= 1'b0;
      case (state)
        IDLE: begin
          if (req_valid) begin
            idx_q         <= req_index;
            tag_q         <= req_tag;
            tried_q       <= '0;
            first_probe_q <= 1'b1;
            state         <= PROBE;
          end
        end
        PROBE: begin
          cand_q             <= probe_way;
          cand_first_q       <= first_probe_q;
          first_probe_q      <= 1'b0;
          tried_q[probe_way] <= 1'b1;
          state              <= CHECK;
        end
        CHECK: begin
          if (hit) begin
            resp_valid <= 1'b1;
            resp_hit   <= 1'b1;
            resp_way   <= cand_q;
            resp_first <= cand_first_q;
            if (!cand_first_q) begin
              wp_update_en  <= 1'b1;
              wp_actual_way <= cand_q;
            end
            state <= RESP;
          end else if (next_found) begin
            cand_q <= next_way;
            state  <= PROBE;
          end else begin
            resp_valid <= 1'b1;
            resp_hit   <= 1'b0;
            resp_way   <= '0;
            resp_first <= 1'b0;
            state      <= RESP;
          end
        end
        RESP: begin
          if (resp_ready) begin
            resp_valid <= 1'b0;
            state      <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

`ifdef WP_LOOKUP_STATS_EN
  // Saturating per-category counters, bumped on each response handshake.
  always_ff @(posedge clk) begin
    if (rst) begin
      stat_first_hit <= '0;
      stat_late_hit  <= '0;
      stat_miss      <= '0;
    end else if (resp_valid && resp_ready) begin
      if (resp_hit && resp_first) begin
        if (stat_first_hit != '1) stat_first_hit <= stat_first_hit + 32'd1;
      end else if (resp_hit) begin
        if (stat_late_hit != '1) stat_late_hit <= stat_late_hit + 32'd1;
      end else begin
        if (stat_miss != '1) stat_miss <= stat_miss + 32'd1;
      end
    end
  end
`endif

endmodule
